// File: rtl/a_plus_b_sharer_pkg.sv
// Shared types and helpers for the round-robin adder sharer and its result buffer.
package a_plus_b_sharer_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned N_REQ_DEF = 4;

  // A one-bit id is still needed when there are only one or two requesters.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 32'd1 : int'($clog2(n));
  endfunction

  localparam int unsigned ID_W_DEF = clog2_min1(N_REQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [WIDTH_DEF-1:0] sum;
  } buf_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/tagged_two_entry_buffer.sv
// Two-entry valid/ready FIFO; up_ready is a flop so the upstream never sees dn_ready.
//
// state     | meaning
// BUF_EMPTY | no entries, dn_valid low
// BUF_ONE   | head holds the only entry
// BUF_FULL  | head and tail both hold entries, up_ready low
module tagged_two_entry_buffer
  import a_plus_b_sharer_pkg::*;
#(
  parameter type entry_t = buf_entry_t
) (
  input  logic   clk,
  input  logic   rst_b,
  input  logic   up_valid,
  output logic   up_ready,
  input  entry_t up_data,
  output logic   dn_valid,
  input  logic   dn_ready,
  output entry_t dn_data
);

  buf_state_t state_q, state_d;
  entry_t     head_q, tail_q;
  logic       push, pop;

  assign push = up_valid & up_ready;
  assign pop  = dn_valid & dn_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= BUF_EMPTY;
      up_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      up_ready <= (state_d != BUF_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_FULL;
        else if (!push && pop) state_d = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Push while full cannot happen: up_ready is low for the whole full cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        BUF_EMPTY: if (push) head_q <= up_data;
        BUF_ONE: begin
          if (push && pop) head_q <= up_data;
          else if (push)   tail_q <= up_data;
        end
        BUF_FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  assign dn_valid = (state_q != BUF_EMPTY);
  assign dn_data  = head_q;

endmodule

// File: rtl/a_plus_b_round_robin_sharer.sv
// Round-robin arbiter feeding one shared adder; results return on the
// granted requester's response lane in acceptance order.
module a_plus_b_round_robin_sharer
  import a_plus_b_sharer_pkg::*;
#(
  parameter  int width = 8,
  parameter  int n_req = 4,
  localparam int id_w  = clog2_min1(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_a,
  input  logic [n_req*width-1:0] req_b,
  output logic [n_req-1:0]       rsp_valid,
  input  logic [n_req-1:0]       rsp_ready,
  output logic [width-1:0]       rsp_data,
  output logic [id_w-1:0]        rsp_id,
  output logic                   busy
);

  typedef struct packed {
    logic [id_w-1:0]  id;
    logic [width-1:0] sum;
  } entry_t;

  logic [id_w-1:0]  ptr_q, grant_id;
  logic [n_req-1:0] grant;
  logic             grant_any, buf_has_space, push, head_valid, pop;
  logic [width-1:0] a_sel, b_sel;
  entry_t           push_entry, head;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 0; off < n_req; off++) begin
      int idx;
      idx = (int'(ptr_q) + off) % n_req;
      if (!grant_any && req_valid[idx]) begin
        grant_any   = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = id_w'(idx);
      end
    end
  end

  assign req_ready = grant & {n_req{buf_has_space}};
  assign push      = grant_any & buf_has_space;

  assign a_sel          = req_a[int'(grant_id)*width +: width];
  assign b_sel          = req_b[int'(grant_id)*width +: width];
  assign push_entry.id  = grant_id;
  assign push_entry.sum = a_sel + b_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (push) begin
      ptr_q <= (grant_id == id_w'(n_req - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  tagged_two_entry_buffer #(
    .entry_t (entry_t)
  ) u_buf (
    .clk      (clk),
    .rst_b    (rst),
    .up_valid (push),
    .up_ready (buf_has_space),
    .up_data  (push_entry),
    .dn_valid (head_valid),
    .dn_ready (pop),
    .dn_data  (head)
  );

  // Only the lane that owns the head can retire it.
  assign pop = head_valid & rsp_ready[head.id];

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < n_req; k++) begin
      rsp_valid[k] = head_valid && (head.id == id_w'(k));
    end
  end

  assign rsp_data = head.sum;
  assign rsp_id   = head.id;
  assign busy     = head_valid;

endmodule

// File: doc/a_plus_b_round_robin_sharer.md
Name: a_plus_b_round_robin_sharer

Overview:
Shares one registered adder datapath among n_req requesters. Each requester presents an (a, b) operand pair on its own valid/ready channel. A round-robin arbiter grants one requester per cycle, and the sum plus the requester id enter a two-entry output buffer. Each result returns on the matching requester's response channel. The block sits between several producer pipelines and a single adder resource, so the design can instantiate one adder instead of n_req.

Parameters:
width, 8, operand and sum width in bits
n_req, 4, number of requesters (2..16)
id_w, $clog2(n_req), requester id width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
req_valid  input  n_req  per-requester operand valid
req_ready  output  n_req  per-requester operand accepted
req_a  input  n_req*width  operand a, requester i at bits [i*width +: width]
req_b  input  n_req*width  operand b, same packing
rsp_valid  output  n_req  per-requester result valid (one-hot or zero)
rsp_ready  input  n_req  per-requester result accept
rsp_data  output  width  sum for the head entry, shared by all rsp lanes
rsp_id  output  id_w  requester id of the head entry
busy  output  1  buffer non-empty

Behaviour:
- Reset (rst=0, async): buffer empty, rr pointer=0, so req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. Reset mid-transfer discards any buffered results with no partial outputs.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, then ptr+1, and so on, wrapping modulo n_req. The first set bit is the grant.
  - Zero or one grant per cycle.
- req_ready[i] = grant[i] & buf_has_space.
  - buf_has_space is a registered signal: "fewer than 2 entries".
  - No combinational path from rsp_ready to any req_ready.
- Transfer on requester i: req_valid[i] & req_ready[i].
  - Pushes {id=i, sum=(a_i+b_i) mod 2^width} into the buffer. Carry out is discarded.
  - ptr <= (i+1) mod n_req.
  - ptr holds when no transfer occurs.
- Requesters must hold valid and data stable until ready. Dropping valid before acceptance is legal: the requester simply loses arbitration.
- Output buffer: two-entry FIFO, head drives rsp_data and rsp_id.
  - rsp_valid[k] = head_valid & (head_id==k).
  - Pop = rsp_valid[rsp_id] & rsp_ready[rsp_id]. rsp_ready on other lanes is ignored.
- Latency: operands accepted at edge t appear as rsp_valid at cycle t+1 if the buffer was empty.
- Throughput: 1 result per cycle when the consumer is always ready.
- Full (2 entries): no push that cycle, even if a pop occurs. This is registered-ready semantics. Space returns the cycle after the pop.
- Push and pop in the same cycle with 1 entry: occupancy stays 1, and the new entry becomes head the next cycle.
- Results leave in acceptance order. A stalled head blocks results for other requesters (head-of-line blocking is accepted by design).
- busy = occupancy != 0.

Decomposition:
- Shared package a_plus_b_sharer_pkg holds:
  - function clog2_min1, which returns 1 for n_req ≤ 2
  - typedef for the buffer entry struct {id, sum}, parameterised by width and id width through the package localparams defaults
- One sub-module, tagged_two_entry_buffer, provides a valid/ready two-entry FIFO with registered up_ready. The top module holds the arbiter, the rr pointer, the adder and the response demux.

Test Plan:
- Reset, then all req_valid=0 → req_ready=0, rsp_valid=0, busy=0. Assert rst=0 mid-stream with 2 entries buffered → rsp_valid drops immediately and ptr=0 after release.
- Single requester 2: a=8'h03, b=8'h04, rsp_ready=1 → req_ready[2]=1 the same cycle; next cycle rsp_valid=4'b0100, rsp_id=2, rsp_data=8'h07.
- All four requesters valid continuously, all rsp_ready=1 → grants in order 0,1,2,3,0,… with one result per cycle.
- Overflow: a=8'hF0, b=8'h20 → rsp_data=8'h10.
- Backpressure: rsp_ready=0 with requesters 0 and 1 valid:
  - two results are buffered (ids 0 then 1) and req_ready stays 0 afterwards
  - raise rsp_ready[1] only → no pop, because the head is id 0
  - raise rsp_ready[0] → id 0 pops, then space reopens one cycle later
- Requester 3 drops valid while not granted (requester 1 holds the grant) → no transfer for 3 and ptr advances only past 1. Each requester's sequence of values returns in order, checked against a scoreboard.
